ddr_port_arbiter: RTL and testbench
===================================

# ddr_port_arbiter

Shares the single picorv-style DDR request port (25-bit byte address, 32-bit data, 4-bit strobe, valid/ready) between NPORTS requesters: CPU, video scanout, DMA. Sits between the requesters and the DDR cache/MIG bridge stack. Captures one request at a time and presents it downstream with stable signals until it completes. Routes the completion back to the winner only.

## Interface
- NPORTS, 3: number of requesters, 2..8; port 0 is the CPU.
- ADDR_W, 25: byte address width.
- DATA_W, 32: data width; strobe width is DATA_W/8.

- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- m_addr  in  NPORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  NPORTS*DATA_W  per-port write data.
- m_wstrb  in  NPORTS*4  per-port byte strobes; all zero means read.
- m_valid  in  NPORTS  per-port request.
- m_ready  out  NPORTS  per-port completion pulse, one-hot or zero.
- m_rdata  out  DATA_W  read data, broadcast to all ports; valid only with that port's m_ready.
- s_addr, s_wdata, s_wstrb  out  ADDR_W / DATA_W / 4  captured request, driven to the DDR cache.
- s_valid  out  1  downstream request.
- s_ready  in  1  downstream completion.
- s_rdata  in  DATA_W  downstream read data.
- grant  out  3  index of the current or most recent winner.
- busy  out  1  high while a transaction is outstanding.

## Operation
- State machine with two states.
  - IDLE: s_valid=0. If any m_valid is high, pick a winner, capture its addr/wdata/wstrb into the s_* registers, load grant, go to BUSY.
  - BUSY: s_valid=1. m_ready[grant]=s_ready (combinational). m_rdata=s_rdata (combinational). On s_ready, go to IDLE.
- s_valid comes from the state only, never from m_valid. If a winner drops m_valid while BUSY (protocol violation), the captured request still runs to completion and the m_ready pulse is still issued.
- Winner selection uses the round-robin pointer rr_ptr.
  - Search starts at rr_ptr and wraps modulo NPORTS. The first port with m_valid high wins.
  - On every grant, rr_ptr becomes (winner+1) mod NPORTS.
- Only the granted port ever sees m_ready. All other m_ready bits are 0 at all times.
- Requests arriving while BUSY wait. No queueing beyond each requester holding its own m_valid.

## Timing
- Reset values: state=IDLE, s_valid=0, s_addr/s_wdata/s_wstrb=0, grant=0, rr_ptr=0, busy=0, m_ready=0.
- Requester protocol: m_valid is held with stable signals until m_ready. The requester may drop m_valid the cycle after m_ready, or immediately raise a new request.
- Latency:
  - m_valid seen in IDLE at cycle 0 → s_valid=1 from cycle 1.
  - s_ready at cycle k → m_ready at cycle k → IDLE at k+1.
  - A new grant is captured at edge k+1, so the next s_valid rises at k+2.
  - Minimum turnaround is 2 cycles per transaction.
- IDLE always inserts one cycle between consecutive downstream requests. This guarantees the completed requester has a cycle to drop m_valid before the next arbitration.
- A winner can hold m_valid across its own completion, which looks like a repeated request. That is a legal back-to-back request. Under round-robin it is rescheduled only after the other pending ports are served.
- Asynchronous reset mid-BUSY: all outputs return to reset values immediately. Downstream must also be reset; an in-flight s_ready after reset is ignored.
- s_ready seen in IDLE is ignored.

## Configuration
- DDR_ARB_RR_EN defined: round-robin selection as described above.
- DDR_ARB_RR_EN undefined:
  - Fixed priority; the lowest index with m_valid wins, so the CPU always wins.
  - rr_ptr is not built.
  - Starvation of high indices is accepted in this mode.

## Structure
- Shared package/header ddr_arb_defs holds:
  - state encodings ARB_IDLE=1'b0, ARB_BUSY=1'b1;
  - DDR_ADDR_W=25 and DDR_DATA_W=32 defaults;
  - a port-index width constant of 3.
- One sub-module, arb_pick. It is combinational: it takes the valid vector and start pointer, and returns a one-hot winner and its index. It is instantiated once, with the start pointer tied to 0 when DDR_ARB_RR_EN is undefined.

## Test plan
- Single read: port 1 requests addr 25'h0001000, wstrb 0. Expect:
  - s_valid at cycle 1 with s_addr=25'h0001000;
  - s_ready with s_rdata=32'hDEADBEEF at cycle 4 → m_ready=3'b010 and m_rdata=32'hDEADBEEF at cycle 4;
  - busy low at cycle 5.
- Contention with round-robin: ports 0, 1 and 2 all request at cycle 0 and re-raise after each completion. Expect grant order 0,1,2,0,1,2 and no m_ready on non-granted ports.
- Fixed priority, macro undefined: ports 0 and 2 request continuously. Expect port 0 granted every time and port 2 never granted.
- Write capture: port 2 writes addr 25'h1FFFFFC, wdata 32'h12345678, wstrb 4'b0011, then changes m_wdata while BUSY. Expect s_wdata to stay 32'h12345678 until s_ready.
- Valid dropped mid-transaction: port 0 drops m_valid at cycle 2 of BUSY. Expect s_valid held until s_ready and a one-cycle m_ready[0] pulse.
- Reset mid-BUSY: assert rst_n=0 at an arbitrary phase. Expect s_valid=0, busy=0 and grant=0 asynchronously, and the next grant to start from port 0.

Source files
------------

// File: rtl/ddr_arb_defs.sv
// Shared definitions for the DDR port arbiter: FSM encodings, default widths
// and the width of a requester index.
package ddr_arb_defs;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int DDR_ADDR_W = 25;
  localparam int DDR_DATA_W = 32;
  localparam int PIDX_W     = 3;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: the first valid port at or after start_i wins,
// wrapping around to port 0. Returns the winner as one-hot and as an index.
module arb_pick
  import ddr_arb_defs::*;
#(
  parameter int NPORTS = 3
) (
  input  logic [NPORTS-1:0] valid_i,
  input  logic [PIDX_W-1:0] start_i,
  output logic [NPORTS-1:0] onehot_o,
  output logic [PIDX_W-1:0] idx_o
);

  logic found;

  // Two passes model the wrap: ports from start_i upward first, then the ones below it.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (!found && valid_i[i] && (PIDX_W'(i) >= start_i)) begin
        found       = 1'b1;
        onehot_o[i] = 1'b1;
        idx_o       = PIDX_W'(i);
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (!found && valid_i[i] && (PIDX_W'(i) < start_i)) begin
        found       = 1'b1;
        onehot_o[i] = 1'b1;
        idx_o       = PIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR request port between NPORTS requesters (port 0 = CPU).
// Define DDR_ARB_RR_EN for round-robin selection; otherwise fixed priority.
module ddr_port_arbiter
  import ddr_arb_defs::*;
#(
  parameter int NPORTS = 3,
  parameter int ADDR_W = DDR_ADDR_W,
  parameter int DATA_W = DDR_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NPORTS*ADDR_W-1:0]     m_addr,
  input  logic [NPORTS*DATA_W-1:0]     m_wdata,
  input  logic [NPORTS*(DATA_W/8)-1:0] m_wstrb,
  input  logic [NPORTS-1:0]            m_valid,
  output logic [NPORTS-1:0]            m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  output logic                         s_valid,
  input  logic                         s_ready,
  input  logic [DATA_W-1:0]            s_rdata,
  output logic [PIDX_W-1:0]            grant,
  output logic                         busy
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q;
  logic [PIDX_W-1:0]   grant_q;
  logic [ADDR_W-1:0]   s_addr_q,  addr_d;
  logic [DATA_W-1:0]   s_wdata_q, wdata_d;
  logic [STRB_W-1:0]   s_wstrb_q, wstrb_d;
  logic [NPORTS-1:0]   pick_oh;
  logic [PIDX_W-1:0]   pick_idx;
  logic [PIDX_W-1:0]   start_ptr;

`ifdef DDR_ARB_RR_EN
  logic [PIDX_W-1:0] rr_ptr_q, rr_ptr_d;

  assign start_ptr = rr_ptr_q;
  assign rr_ptr_d  = (pick_idx == PIDX_W'(NPORTS - 1)) ? '0 : pick_idx + PIDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (state_q == ARB_IDLE && |m_valid) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign start_ptr = '0;
`endif

  arb_pick #(.NPORTS(NPORTS)) u_pick (
    .valid_i  (m_valid),
    .start_i  (start_ptr),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    wstrb_d = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (pick_oh[i]) begin
        addr_d  = m_addr[i*ADDR_W +: ADDR_W];
        wdata_d = m_wdata[i*DATA_W +: DATA_W];
        wstrb_d = m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // The request is frozen at capture, so requester misbehaviour while BUSY cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|m_valid) begin
            state_q   <= ARB_BUSY;
            grant_q   <= pick_idx;
            s_addr_q  <= addr_d;
            s_wdata_q <= wdata_d;
            s_wstrb_q <= wstrb_d;
          end
        end
        ARB_BUSY: begin
          if (s_ready) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    m_ready = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (state_q == ARB_BUSY && s_ready && grant_q == PIDX_W'(i)) begin
        m_ready[i] = 1'b1;
      end
    end
  end

  assign m_rdata = s_rdata;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wstrb = s_wstrb_q;
  assign s_valid = (state_q == ARB_BUSY);
  assign busy    = (state_q == ARB_BUSY);
  assign grant   = grant_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed testbench for ddr_port_arbiter; expected grant orders follow
// DDR_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module tb_ddr_port_arbiter;

  localparam int NPORTS = 3;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;

  logic                     clk;
  logic                     rst_n;
  logic [NPORTS*ADDR_W-1:0] m_addr;
  logic [NPORTS*DATA_W-1:0] m_wdata;
  logic [NPORTS*4-1:0]      m_wstrb;
  logic [NPORTS-1:0]        m_valid;
  logic [NPORTS-1:0]        m_ready;
  logic [DATA_W-1:0]        m_rdata;
  logic [ADDR_W-1:0]        s_addr;
  logic [DATA_W-1:0]        s_wdata;
  logic [3:0]               s_wstrb;
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_W-1:0]        s_rdata;
  logic [2:0]               grant;
  logic                     busy;

  int testsRun;
  int testsFailed;
  int expCont[6];
  int exp02[3];

  ddr_port_arbiter #(.NPORTS(NPORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_rdata (s_rdata),
    .grant   (grant),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [3:0] s);
    m_addr[p*ADDR_W +: ADDR_W]  = a;
    m_wdata[p*DATA_W +: DATA_W] = d;
    m_wstrb[p*4 +: 4]           = s;
  endtask

  // One complete transaction with s_ready in the first BUSY cycle; requesters keep their m_valid.
  task automatic runTxn(input string tag, input int expGrant);
    tick();
    checkOutput({tag, "_grant"}, grant, expGrant);
    checkOutput({tag, "_svalid"}, s_valid, 1'b1);
    s_ready = 1'b1;
    #1;
    checkOutput({tag, "_mready"}, m_ready, 3'(1 << expGrant));
    tick();
    s_ready = 1'b0;
    #1;
    checkOutput({tag, "_idle_gap"}, s_valid, 1'b0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
`ifdef DDR_ARB_RR_EN
    expCont = '{0, 1, 2, 0, 1, 2};
    exp02   = '{0, 2, 0};
`else
    expCont = '{0, 0, 0, 0, 0, 0};
    exp02   = '{0, 0, 0};
`endif
    rst_n   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    m_valid = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    #1;
    checkOutput("rst_svalid", s_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant", grant, 3'd0);
    checkOutput("rst_mready", m_ready, 3'b000);
    checkOutput("rst_saddr", s_addr, 25'h0);
    checkOutput("rst_swdata", s_wdata, 32'h0);
    checkOutput("rst_swstrb", s_wstrb, 4'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single read from port 1
    applyStimulus(1, 25'h0001000, 32'h0, 4'b0000);
    m_valid = 3'b010;
    tick();
    checkOutput("rd_svalid_c1", s_valid, 1'b1);
    checkOutput("rd_saddr_c1", s_addr, 25'h0001000);
    checkOutput("rd_swstrb_c1", s_wstrb, 4'b0000);
    checkOutput("rd_grant_c1", grant, 3'd1);
    checkOutput("rd_busy_c1", busy, 1'b1);
    checkOutput("rd_mready_c1", m_ready, 3'b000);
    tick();
    tick();
    tick();
    s_ready = 1'b1;
    s_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("rd_mready_c4", m_ready, 3'b010);
    checkOutput("rd_mrdata_c4", m_rdata, 32'hDEADBEEF);
    tick();
    m_valid = 3'b000;
    #1;
    checkOutput("rd_busy_c5", busy, 1'b0);
    checkOutput("rd_mready_idle_sready", m_ready, 3'b000);
    s_ready = 1'b0;
    tick();
    checkOutput("rd_stays_idle", s_valid, 1'b0);

    // Contention among all ports from a fresh reset
    rst_n = 1'b0;
    #2;
    checkOutput("cont_rst_grant", grant, 3'd0);
    rst_n = 1'b1;
    applyStimulus(0, 25'h0000100, 32'h0, 4'b0000);
    applyStimulus(1, 25'h0000200, 32'h0, 4'b0000);
    applyStimulus(2, 25'h0000300, 32'h0, 4'b0000);
    m_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      runTxn($sformatf("cont%0d", n), expCont[n]);
    end

    // Ports 0 and 2 requesting continuously
    m_valid = 3'b101;
    for (int n = 0; n < 3; n++) begin
      runTxn($sformatf("p02_%0d", n), exp02[n]);
    end
    m_valid = 3'b000;
    tick();
    checkOutput("p02_idle", busy, 1'b0);

    // Write capture stays frozen while the requester changes its data
    applyStimulus(2, 25'h1FFFFFC, 32'h12345678, 4'b0011);
    m_valid = 3'b100;
    tick();
    checkOutput("wr_grant", grant, 3'd2);
    checkOutput("wr_saddr", s_addr, 25'h1FFFFFC);
    checkOutput("wr_swdata", s_wdata, 32'h12345678);
    checkOutput("wr_swstrb", s_wstrb, 4'b0011);
    applyStimulus(2, 25'h1FFFFFC, 32'hCAFEF00D, 4'b0011);
    tick();
    checkOutput("wr_swdata_hold1", s_wdata, 32'h12345678);
    tick();
    s_ready = 1'b1;
    #1;
    checkOutput("wr_swdata_hold2", s_wdata, 32'h12345678);
    checkOutput("wr_mready", m_ready, 3'b100);
    tick();
    s_ready = 1'b0;
    m_valid = 3'b000;
    #1;
    checkOutput("wr_idle", s_valid, 1'b0);

    // Port 0 drops m_valid mid-transaction
    applyStimulus(0, 25'h0000040, 32'h0, 4'b0000);
    m_valid = 3'b001;
    tick();
    checkOutput("drop_grant", grant, 3'd0);
    tick();
    m_valid = 3'b000;
    #1;
    checkOutput("drop_svalid_c2", s_valid, 1'b1);
    tick();
    checkOutput("drop_svalid_c3", s_valid, 1'b1);
    s_ready = 1'b1;
    #1;
    checkOutput("drop_mready", m_ready, 3'b001);
    tick();
    s_ready = 1'b0;
    #1;
    checkOutput("drop_mready_once", m_ready, 3'b000);
    checkOutput("drop_svalid_end", s_valid, 1'b0);

    // Asynchronous reset while BUSY
    applyStimulus(1, 25'h0000ABC, 32'h0, 4'b0000);
    m_valid = 3'b010;
    tick();
    checkOutput("arst_pre_grant", grant, 3'd1);
    checkOutput("arst_pre_busy", busy, 1'b1);
    #2;
    rst_n   = 1'b0;
    s_ready = 1'b1;
    #1;
    checkOutput("arst_svalid", s_valid, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_grant", grant, 3'd0);
    checkOutput("arst_mready", m_ready, 3'b000);
    checkOutput("arst_saddr", s_addr, 25'h0);
    #1;
    rst_n   = 1'b1;
    s_ready = 1'b0;
    m_valid = 3'b011;
    runTxn("arst_next", 0);
    m_valid = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
